// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU controller: opcodes, frame layout,
// controller states and the two CRC helpers used on the serial links.
package alu_pkg;

  typedef enum logic [2:0] {
    AND_OP = 3'b000,
    OR_OP  = 3'b001,
    ADD_OP = 3'b100,
    SUB_OP = 3'b101
  } operation_t;

  localparam int unsigned FRAME_LEN   = 11;
  localparam int unsigned DATA_FRAMES = 4;
  // 4 B frames, 4 A frames and one ctl frame
  localparam int unsigned TX_BITS     = FRAME_LEN * (2 * DATA_FRAMES + 1);
  localparam logic        TYPE_DATA   = 1'b0;
  localparam logic        TYPE_CTL    = 1'b1;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} ctrl_state_t;

  // CRC4, poly x^4+x+1, init 0, MSB first
  function automatic logic [3:0] crc4_calc(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // CRC3, poly x^3+x+1, init 0, MSB first
  function automatic logic [2:0] crc3_calc(input logic [36:0] d);
    logic [2:0] c;
    logic       fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

  // Start bit, type, payload MSB first, stop bit
  function automatic logic [FRAME_LEN-1:0] mk_frame(input logic t, input logic [7:0] p);
    return {1'b0, t, p, 1'b1};
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Deserializes the ten bits following an already-consumed start bit.
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       din,
  output logic       busy,
  output logic       frame_done,
  output logic       ftype,
  output logic [7:0] payload,
  output logic       stop_ok
);

  logic [3:0]           cnt;
  logic [FRAME_LEN-2:0] sh;

  // Shift in type, payload and stop; pulse frame_done after the stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      cnt        <= '0;
      sh         <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        sh <= {sh[FRAME_LEN-3:0], din};
        if (cnt == 4'(FRAME_LEN - 2)) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

  assign ftype   = sh[FRAME_LEN-2];
  assign payload = sh[FRAME_LEN-3:1];
  assign stop_ok = sh[0];

endmodule

// File: rtl/alu_serial_ctrl.sv
// Sequencer: serializes one {A, B, op} request to the ALU, collects and
// checks the serial response and presents it on a valid/ready port.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic        sin,
  input  logic        sout,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_c,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [5:0]  rsp_err_flags,
  output logic        rsp_chk_fail,
  output logic        rsp_timeout
);

  ctrl_state_t        state;
  logic [TX_BITS-2:0] tx_sh;
  logic [6:0]         bit_cnt;
  logic [CNT_W-1:0]   timer;
  logic [2:0]         frm;

  logic [TX_BITS-1:0] tx_stream;
  logic [3:0]         tx_crc;
  logic               rx_busy, rx_done, rx_type, rx_stop_ok;
  logic [7:0]         rx_payload;
  logic               rx_end, listen, rx_start;

  // Whole outgoing bit stream, built from the live request inputs
  always_comb begin
    tx_crc    = crc4_calc({req_b, req_a, 1'b1, req_op});
    tx_stream = {mk_frame(TYPE_DATA, req_b[31:24]), mk_frame(TYPE_DATA, req_b[23:16]),
                 mk_frame(TYPE_DATA, req_b[15:8]),  mk_frame(TYPE_DATA, req_b[7:0]),
                 mk_frame(TYPE_DATA, req_a[31:24]), mk_frame(TYPE_DATA, req_a[23:16]),
                 mk_frame(TYPE_DATA, req_a[15:8]),  mk_frame(TYPE_DATA, req_a[7:0]),
                 mk_frame(TYPE_CTL, {1'b0, req_op, tx_crc})};
  end

  // Frame-level receive decisions: last frame seen, and when to hunt for a start bit
  always_comb begin
    rx_end   = rx_done && ((frm == 3'd0 && rx_type == TYPE_CTL) || frm == 3'(DATA_FRAMES));
    listen   = (state == WAIT) || (state == RECV && !rx_busy && !rx_end);
    rx_start = listen && !sout;
  end

  alu_frame_rx u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (rx_start),
    .din        (sout),
    .busy       (rx_busy),
    .frame_done (rx_done),
    .ftype      (rx_type),
    .payload    (rx_payload),
    .stop_ok    (rx_stop_ok)
  );

  // Controller FSM with registered handshake, serial and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sin           <= 1'b1;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_c         <= '0;
      rsp_flags     <= '0;
      rsp_err       <= 1'b0;
      rsp_err_flags <= '0;
      rsp_chk_fail  <= 1'b0;
      rsp_timeout   <= 1'b0;
      tx_sh         <= '0;
      bit_cnt       <= '0;
      timer         <= '0;
      frm           <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            sin           <= tx_stream[TX_BITS-1];
            tx_sh         <= tx_stream[TX_BITS-2:0];
            bit_cnt       <= 7'(TX_BITS - 1);
            req_ready     <= 1'b0;
            rsp_c         <= '0;
            rsp_flags     <= '0;
            rsp_err       <= 1'b0;
            rsp_err_flags <= '0;
            rsp_chk_fail  <= 1'b0;
            rsp_timeout   <= 1'b0;
            timer         <= '0;
            frm           <= '0;
            state         <= SEND;
          end
        end
        SEND: begin
          if (bit_cnt == 7'd0) begin
            sin   <= 1'b1;
            timer <= '0;
            state <= WAIT;
          end else begin
            sin     <= tx_sh[TX_BITS-2];
            tx_sh   <= {tx_sh[TX_BITS-3:0], 1'b0};
            bit_cnt <= bit_cnt - 7'd1;
          end
        end
        WAIT, RECV: begin
          if (rx_done) begin
            if (frm == 3'd0 && rx_type == TYPE_CTL) begin
              rsp_err       <= 1'b1;
              rsp_err_flags <= rx_payload[6:1];
              rsp_chk_fail  <= (^rx_payload[7:1] != rx_payload[0]) || !rx_stop_ok;
            end else if (frm == 3'(DATA_FRAMES)) begin
              rsp_flags    <= rx_payload[6:3];
              rsp_chk_fail <= rsp_chk_fail || rx_type == TYPE_DATA || !rx_stop_ok ||
                              crc3_calc({rsp_c, 1'b0, rx_payload[6:3]}) != rx_payload[2:0];
            end else begin
              rsp_c <= {rsp_c[23:0], rx_payload};
              frm   <= frm + 3'd1;
              if (!rx_stop_ok) rsp_chk_fail <= 1'b1;
            end
          end
          if (rx_end) begin
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else if (rx_start) begin
            timer <= '0;
            state <= RECV;
          end else if (listen) begin
            // timer holds the idle cycles already seen; this one is the next
            if (timer == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              rsp_timeout <= 1'b1;
              rsp_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              timer <= timer + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Bench for alu_serial_ctrl: a behavioural ALU on the far side of the serial
// lines plus a per-cycle checker of the response port.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int unsigned TO = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [2:0]  req_op = '0;
  logic        sout = 1'b1;
  logic        rsp_ready = 1'b1;
  logic        req_ready, sin, rsp_valid, rsp_err, rsp_chk_fail, rsp_timeout;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic [5:0]  rsp_err_flags;

  alu_serial_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .sin(sin), .sout(sout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .rsp_err_flags(rsp_err_flags), .rsp_chk_fail(rsp_chk_fail),
    .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference CRCs as polynomial long division of d(x)*x^n by g(x)
  function automatic logic [3:0] ref_crc4(input logic [67:0] d);
    logic [71:0] r;
    r = {d, 4'b0};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_crc3(input logic [36:0] d);
    logic [39:0] r;
    r = {d, 3'b0};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] a, b, input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b100:  return a + b;
      3'b101:  return a - b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_flags(input logic [31:0] a, b, input logic [2:0] op);
    logic [32:0] w;
    logic [31:0] c;
    logic        cy, ov;
    c  = ref_alu(a, b, op);
    cy = 1'b0;
    ov = 1'b0;
    if (op == 3'b100) begin
      w  = {1'b0, a} + {1'b0, b};
      cy = w[32];
      ov = (a[31] == b[31]) && (c[31] != a[31]);
    end else if (op == 3'b101) begin
      cy = a < b;
      ov = (a[31] != b[31]) && (c[31] != a[31]);
    end
    return {cy, ov, c == 32'h0, c[31]};
  endfunction

  // Expected 99-bit sin stream: B bytes, A bytes (MSB byte first), ctl frame
  function automatic logic [98:0] ref_tx(input logic [31:0] a, b, input logic [2:0] op);
    logic [98:0] s;
    logic [7:0]  by;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      by = (i < 4) ? 8'(b >> (24 - 8 * i)) : 8'(a >> (24 - 8 * (i - 4)));
      s[98 - 11 * i -: 11] = {1'b0, 1'b0, by, 1'b1};
    end
    s[10:0] = {1'b0, 1'b1, 1'b0, op, ref_crc4({b, a, 1'b1, op}), 1'b1};
    return s;
  endfunction

  // Expected response fields, set by each test before the ALU answers
  logic [31:0] exp_c = '0;
  logic [3:0]  exp_flags = '0;
  logic        exp_err = 1'b0;
  logic [5:0]  exp_eflags = '0;
  logic        exp_chk = 1'b0;
  logic        exp_to = 1'b0;
  int          valid_rises = 0;
  logic        valid_prev = 1'b0;

  // Response checker: every cycle the response is valid it must match the model
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (!valid_prev) valid_rises++;
      check("rsp_c", rsp_c, exp_c);
      check("rsp_flags", rsp_flags, exp_flags);
      check("rsp_err", rsp_err, exp_err);
      check("rsp_err_flags", rsp_err_flags, exp_eflags);
      check("rsp_chk_fail", rsp_chk_fail, exp_chk);
      check("rsp_timeout", rsp_timeout, exp_to);
    end
    valid_prev = rst_n && rsp_valid;
  end

  task automatic send_frame(input logic t, input logic [7:0] p);
    logic [10:0] f;
    f = {1'b0, t, p, 1'b1};
    for (int j = 10; j >= 0; j--) begin
      @(negedge clk);
      sout = f[j];
    end
  endtask

  // Present a request and wait (bounded) for it to be taken
  task automatic issue(input string tag, input logic [31:0] a, b, input logic [2:0] op);
    int w;
    @(negedge clk);
    req_a = a;
    req_b = b;
    req_op = op;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_accept"}, req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // mode: 0 normal, 1 error frame, 2 silent ALU, 3 corrupted crc3
  task automatic run_txn(input string tag, input logic [31:0] a, b, input logic [2:0] op,
                         input int mode, input logic [5:0] err, input int gap, input int hold,
                         input logic [31:0] lit_c);
    logic [98:0] got_tx;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [2:0]  k3;
    int          n, rises0;
    c  = ref_alu(a, b, op);
    fl = ref_flags(a, b, op);
    k3 = ref_crc3({c, 1'b0, fl});
    exp_c      = (mode == 0 || mode == 3) ? c : 32'h0;
    exp_flags  = (mode == 0 || mode == 3) ? fl : 4'h0;
    exp_err    = (mode == 1);
    exp_eflags = (mode == 1) ? err : 6'h0;
    exp_chk    = (mode == 3);
    exp_to     = (mode == 2);
    rsp_ready  = (hold == 0);
    rises0     = valid_rises;
    issue(tag, a, b, op);
    for (int i = 98; i >= 0; i--) begin
      got_tx[i] = sin;
      if (i == 50) check({tag, "_busy_ready"}, req_ready, 1'b0);
      if (i > 0) @(negedge clk);
    end
    check({tag, "_sin"}, got_tx, ref_tx(a, b, op));
    n = 0;
    if (mode == 2) begin
      @(negedge clk);
      while (!rsp_valid && n < 400) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_idle_cycles"}, n, TO);
    end else begin
      repeat (2) @(negedge clk);
      if (mode == 1) begin
        send_frame(1'b1, {1'b1, err, ^{1'b1, err}});
      end else begin
        for (int f = 0; f < 4; f++) begin
          send_frame(1'b0, 8'(c >> (24 - 8 * f)));
          if (f == 1) repeat (gap) @(negedge clk);
        end
        send_frame(1'b1, {1'b0, fl, k3 ^ ((mode == 3) ? 3'b001 : 3'b000)});
      end
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    check({tag, "_lit_c"}, rsp_c, lit_c);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, rsp_valid, 1'b1);
      check({tag, "_hold_ready"}, req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid_drop"}, rsp_valid, 1'b0);
    check({tag, "_ready_back"}, req_ready, 1'b1);
    check({tag, "_one_rsp"}, valid_rises - rises0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_sin", sin, 1'b1);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_c", rsp_c, 32'h0);
    check("reset_rsp_bits", {rsp_flags, rsp_err, rsp_err_flags, rsp_chk_fail, rsp_timeout}, 0);
    rst_n = 1'b1;

    // Pin the reference model with hand-derived values
    check("model_crc4_1", ref_crc4(68'h1), 4'h3);
    check("model_crc4_2", ref_crc4(68'h2), 4'h6);
    check("model_crc3_1", ref_crc3(37'h1), 3'h3);
    check("model_crc3_2", ref_crc3(37'h2), 3'h6);
    check("model_add", ref_flags(32'd5, 32'd3, 3'b100), 4'h0);

    run_txn("add", 32'd5, 32'd3, 3'b100, 0, 6'h0, 0, 0, 32'h0000_0008);
    run_txn("and", 32'hFFFF_FFFF, 32'h0000_FFFF, 3'b000, 0, 6'h0, 3, 0, 32'h0000_FFFF);
    run_txn("errf", 32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 1, 6'b100100, 0, 0, 32'h0);
    check("errf_flags_lit", rsp_err_flags, 6'b100100);
    run_txn("tmo", 32'hDEAD_BEEF, 32'h0000_0001, 3'b100, 2, 6'h0, 0, 0, 32'h0);
    run_txn("after_tmo", 32'h00F0_0F00, 32'h0F00_00F0, 3'b001, 0, 6'h0, 1, 0, 32'h0FF0_0FF0);
    run_txn("crcbad", 32'd1, 32'd2, 3'b101, 3, 6'h0, 0, 0, 32'hFFFF_FFFF);

    // Reset in the middle of SEND, around bit 40
    issue("rst", 32'hAAAA_5555, 32'h5555_AAAA, 3'b100);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_sin", sin, 1'b1);
    check("rst_mid_req_ready", req_ready, 1'b1);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_txn("hold", 32'h7FFF_FFFF, 32'd1, 3'b100, 0, 6'h0, 0, 10, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
